// File: rtl/target_pkg.sv
// rtl/target_pkg.sv - shared types, widths and accumulator clear value for target_tracker
package target_pkg;

  localparam int NUM_COLOURS = 5;
  localparam int COORD_W     = 9;
  localparam int CNT_W       = 17;
  localparam int SUM_W       = CNT_W + COORD_W;

  typedef enum logic [2:0] {
    ORANGE = 3'd0,
    PINK   = 3'd1,
    PURPLE = 3'd2,
    BLUE   = 3'd3,
    GREEN  = 3'd4
  } colour_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIV    = 2'd2,
    REPORT = 2'd3
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0]   count;
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
    logic [SUM_W-1:0]   sum_x;
    logic [SUM_W-1:0]   sum_y;
  } track_rec_t;

  // Min fields start at all-ones so the first flagged pixel always wins the compare.
  function automatic track_rec_t rec_clear();
    track_rec_t r;
    r.count = '0;
    r.x_min = '1;
    r.x_max = '0;
    r.y_min = '1;
    r.y_max = '0;
    r.sum_x = '0;
    r.sum_y = '0;
    return r;
  endfunction

endpackage

// File: rtl/target_divider.sv
// rtl/target_divider.sv - restoring unsigned divider, one quotient bit per cycle
// Start latches operands; done pulses N_W cycles later (next cycle for divisor 0, quotient 0).
module target_divider #(
  parameter int N_W = 26,
  parameter int D_W = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [N_W-1:0] i_dividend,
  input  logic [D_W-1:0] i_divisor,
  output logic           o_done,
  output logic [N_W-1:0] o_quotient
);

  localparam int CNT_BITS = $clog2(N_W + 1);

  logic [D_W:0]          r_rem;
  logic [N_W-1:0]        r_quo;
  logic [D_W-1:0]        r_div;
  logic [CNT_BITS-1:0]   r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [D_W:0]          w_shift;
  logic                  w_ge;
  logic [D_W:0]          w_rem_nxt;

  assign w_shift   = {r_rem[D_W-1:0], r_quo[N_W-1]};
  assign w_ge      = w_shift >= {1'b0, r_div};
  assign w_rem_nxt = w_ge ? (w_shift - {1'b0, r_div}) : w_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= '0;
        r_div  <= i_divisor;
        r_cnt  <= CNT_BITS'(N_W);
        r_busy <= (i_divisor != '0);
        r_done <= (i_divisor == '0);
        r_quo  <= (i_divisor == '0) ? '0 : i_dividend;
      end else if (r_busy) begin
        r_rem <= w_rem_nxt;
        r_quo <= {r_quo[N_W-2:0], w_ge};
        r_cnt <= r_cnt - CNT_BITS'(1);
        if (r_cnt == CNT_BITS'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule

// File: rtl/target_tracker.sv
// rtl/target_tracker.sv - per-colour pixel count and bounding box over one frame, reported per colour
// Optional CENTROID_EN adds per-colour centroid via two target_divider instances.
module target_tracker
  import target_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [4:0]         in_flags,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_colour,
  output logic               out_found,
  output logic [CNT_W-1:0]   out_count,
  output logic [COORD_W-1:0] out_x_min,
  output logic [COORD_W-1:0] out_x_max,
  output logic [COORD_W-1:0] out_y_min,
  output logic [COORD_W-1:0] out_y_max,
  output logic [COORD_W-1:0] out_cx,
  output logic [COORD_W-1:0] out_cy,
  output logic               out_last
);

  state_e             r_state, w_state_nxt;
  state_e             w_first_rpt, w_next_rpt;
  logic [COORD_W-1:0] r_x, r_y, w_cur_x, w_cur_y;
  logic [2:0]         r_idx, w_idx_nxt;
  track_rec_t         r_rec     [NUM_COLOURS];
  track_rec_t         w_rec_nxt [NUM_COLOURS];
  track_rec_t         w_out_rec;
  logic               w_beat, w_pix, w_found, w_div_done;

  assign in_ready  = (r_state == IDLE) || (r_state == ACCUM);
  assign w_beat    = in_valid && in_ready;
  // A sop beat is pixel (0,0) whether it arrives in IDLE or mid-frame.
  assign w_pix     = w_beat && (in_sop || (r_state == ACCUM));
  assign w_cur_x   = in_sop ? '0 : r_x;
  assign w_cur_y   = in_sop ? '0 : r_y;
  assign w_idx_nxt = (r_idx == 3'(GREEN)) ? 3'd0 : r_idx + 3'd1;
  assign w_out_rec = r_rec[r_idx];

  always_comb begin
    for (int c = 0; c < NUM_COLOURS; c++) begin
      w_rec_nxt[c] = in_sop ? rec_clear() : r_rec[c];
      if (in_flags[c] && (w_rec_nxt[c].count != '1)) begin
        w_rec_nxt[c].count = w_rec_nxt[c].count + CNT_W'(1);
        if (w_cur_x < w_rec_nxt[c].x_min) w_rec_nxt[c].x_min = w_cur_x;
        if (w_cur_x > w_rec_nxt[c].x_max) w_rec_nxt[c].x_max = w_cur_x;
        if (w_cur_y < w_rec_nxt[c].y_min) w_rec_nxt[c].y_min = w_cur_y;
        if (w_cur_y > w_rec_nxt[c].y_max) w_rec_nxt[c].y_max = w_cur_y;
`ifdef CENTROID_EN
        w_rec_nxt[c].sum_x = w_rec_nxt[c].sum_x + SUM_W'(w_cur_x);
        w_rec_nxt[c].sum_y = w_rec_nxt[c].sum_y + SUM_W'(w_cur_y);
`endif
      end
    end
  end

`ifdef CENTROID_EN
  assign w_first_rpt = (w_rec_nxt[0].count != '0) ? DIV : REPORT;
  assign w_next_rpt  = (r_rec[w_idx_nxt].count != '0) ? DIV : REPORT;
`else
  assign w_first_rpt = REPORT;
  assign w_next_rpt  = REPORT;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pix) w_state_nxt = in_eop ? w_first_rpt : ACCUM;
      ACCUM:   if (w_pix && in_eop) w_state_nxt = w_first_rpt;
      DIV:     if (w_div_done) w_state_nxt = REPORT;
      REPORT:  if (out_ready) w_state_nxt = (r_idx == 3'(GREEN)) ? IDLE : w_next_rpt;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_idx   <= '0;
      for (int c = 0; c < NUM_COLOURS; c++) r_rec[c] <= rec_clear();
    end else begin
      r_state <= w_state_nxt;
      if (w_pix) begin
        r_rec <= w_rec_nxt;
        if (in_eop) begin
          r_x <= '0;
          r_y <= '0;
        end else if (w_cur_x == COORD_W'(WIDTH - 1)) begin
          r_x <= '0;
          r_y <= (w_cur_y == COORD_W'(HEIGHT - 1)) ? w_cur_y : w_cur_y + COORD_W'(1);
        end else begin
          r_x <= w_cur_x + COORD_W'(1);
          r_y <= w_cur_y;
        end
      end
      if ((r_state == REPORT) && out_ready) begin
        r_idx <= w_idx_nxt;
        if (r_idx == 3'(GREEN)) begin
          for (int c = 0; c < NUM_COLOURS; c++) r_rec[c] <= rec_clear();
        end
      end
    end
  end

  assign out_valid  = (r_state == REPORT);
  assign w_found    = (w_out_rec.count != '0);
  assign out_colour = out_valid ? r_idx : 3'd0;
  assign out_found  = out_valid && w_found;
  assign out_count  = out_valid ? w_out_rec.count : '0;
  assign out_x_min  = out_found ? w_out_rec.x_min : '0;
  assign out_x_max  = out_found ? w_out_rec.x_max : '0;
  assign out_y_min  = out_found ? w_out_rec.y_min : '0;
  assign out_y_max  = out_found ? w_out_rec.y_max : '0;
  assign out_last   = out_valid && (r_idx == 3'(GREEN));

`ifdef CENTROID_EN
  logic               r_div_start;
  logic               w_done_x, w_done_y;
  logic [SUM_W-1:0]   w_qx, w_qy;
  logic [COORD_W-1:0] r_cx, r_cy;
  logic               w_unused_q;

  // Start fires in the first DIV cycle, once r_idx and the record are settled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_start <= 1'b0;
      r_cx        <= '0;
      r_cy        <= '0;
    end else begin
      r_div_start <= (w_state_nxt == DIV) && (r_state != DIV);
      if (w_done_x) r_cx <= w_qx[COORD_W-1:0];
      if (w_done_y) r_cy <= w_qy[COORD_W-1:0];
    end
  end

  target_divider #(.N_W(SUM_W), .D_W(CNT_W)) u_div_x (
    .clk        (clk),
    .rst        (rst),
    .i_start    (r_div_start),
    .i_dividend (w_out_rec.sum_x),
    .i_divisor  (w_out_rec.count),
    .o_done     (w_done_x),
    .o_quotient (w_qx)
  );

  target_divider #(.N_W(SUM_W), .D_W(CNT_W)) u_div_y (
    .clk        (clk),
    .rst        (rst),
    .i_start    (r_div_start),
    .i_dividend (w_out_rec.sum_y),
    .i_divisor  (w_out_rec.count),
    .o_done     (w_done_y),
    .o_quotient (w_qy)
  );

  assign w_div_done = w_done_x;
  assign out_cx     = out_found ? r_cx : '0;
  assign out_cy     = out_found ? r_cy : '0;
  assign w_unused_q = ^{w_qx[SUM_W-1:COORD_W], w_qy[SUM_W-1:COORD_W]};
`else
  logic w_unused_sums;

  assign w_div_done    = 1'b0;
  assign out_cx        = '0;
  assign out_cy        = '0;
  assign w_unused_sums = ^{w_out_rec.sum_x, w_out_rec.sum_y};
`endif

endmodule

// File: tb/tb_target_tracker.sv
// tb/tb_target_tracker.sv - directed self-checking bench for target_tracker (WIDTH=8, HEIGHT=4)
module tb_target_tracker;
  import target_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, in_sop, in_eop;
  logic [4:0]         in_flags;
  logic               out_valid, out_ready, out_found, out_last;
  logic [2:0]         out_colour;
  logic [CNT_W-1:0]   out_count;
  logic [COORD_W-1:0] out_x_min, out_x_max, out_y_min, out_y_max, out_cx, out_cy;

  int n_assert = 0;
  int n_fail   = 0;
  logic [4:0] px [64];

  always #5 clk = ~clk;

  target_tracker #(.WIDTH(8), .HEIGHT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_flags   (in_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_colour (out_colour),
    .out_found  (out_found),
    .out_count  (out_count),
    .out_x_min  (out_x_min),
    .out_x_max  (out_x_max),
    .out_y_min  (out_y_min),
    .out_y_max  (out_y_max),
    .out_cx     (out_cx),
    .out_cy     (out_cy),
    .out_last   (out_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic sop, input logic eop, input logic [4:0] flags);
    in_valid = 1'b1;
    in_sop   = sop;
    in_eop   = eop;
    in_flags = flags;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_flags = 5'b0;
  endtask

  task automatic clear_px();
    for (int i = 0; i < 64; i++) px[i] = 5'b0;
  endtask

  task automatic run_frame(input int n);
    for (int i = 0; i < n; i++) beat(i == 0, i == n - 1, px[i]);
    @(negedge clk);
  endtask

  task automatic get_rec(input int col, input int cnt, input int xmin, input int xmax,
                         input int ymin, input int ymax, input int cx, input int cy);
    int t;
    t = 0;
    while (out_valid !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("rec%0d_valid", col), 32'(out_valid), 32'd1);
    chk($sformatf("rec%0d_colour", col), 32'(out_colour), 32'(col));
    chk($sformatf("rec%0d_found", col), 32'(out_found), 32'(cnt != 0));
    chk($sformatf("rec%0d_count", col), 32'(out_count), 32'(cnt));
    chk($sformatf("rec%0d_x_min", col), 32'(out_x_min), 32'(xmin));
    chk($sformatf("rec%0d_x_max", col), 32'(out_x_max), 32'(xmax));
    chk($sformatf("rec%0d_y_min", col), 32'(out_y_min), 32'(ymin));
    chk($sformatf("rec%0d_y_max", col), 32'(out_y_max), 32'(ymax));
    chk($sformatf("rec%0d_last", col), 32'(out_last), 32'(col == 4));
    chk($sformatf("rec%0d_in_ready", col), 32'(in_ready), 32'd0);
`ifdef CENTROID_EN
    chk($sformatf("rec%0d_cx", col), 32'(out_cx), 32'(cx));
    chk($sformatf("rec%0d_cy", col), 32'(out_cy), 32'(cy));
`else
    chk($sformatf("rec%0d_cx", col), 32'(out_cx), 32'd0);
    chk($sformatf("rec%0d_cy", col), 32'(out_cy), 32'd0 + 32'(cy & 0));
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic empty_rec(input int col);
    get_rec(col, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_flags  = 5'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check_idle("reset");
    chk("reset_count", 32'(out_count), 32'd0);
    chk("reset_x_min", 32'(out_x_min), 32'd0);
    chk("reset_last", 32'(out_last), 32'd0);

    // 1: reset mid-frame, then stray non-sop beats (one with eop) must be dropped
    beat(1'b1, 1'b0, 5'b00001);
    beat(1'b0, 1'b0, 5'b00001);
    beat(1'b0, 1'b0, 5'b00001);
    rst = 1'b1;
    #1;
    check_idle("rst_mid_accum");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    beat(1'b0, 1'b0, 5'b00001);
    beat(1'b0, 1'b1, 5'b00001);
    @(negedge clk);
    check_idle("rst_no_report");

    // 2/3: orange at (2,1),(5,3); hold rec0 for 10 cycles
    clear_px();
    px[10] = 5'b00001;
    px[29] = 5'b00001;
    run_frame(32);
    chk("eop_latency_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_count", 32'(out_count), 32'd2);
      chk("hold_x_max", 32'(out_x_max), 32'd5);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    get_rec(0, 2, 2, 5, 1, 3, 3, 2);
    for (int c = 1; c < 5; c++) empty_rec(c);
    check_idle("after_frame2");

    // 4: six dropped pink beats, then pink only at (7,0)
    for (int k = 0; k < 6; k++) beat(1'b0, k == 5, 5'b00010);
    @(negedge clk);
    check_idle("drop_no_sop");
    clear_px();
    px[7] = 5'b00010;
    run_frame(32);
    empty_rec(0);
    get_rec(1, 1, 7, 7, 0, 0, 7, 0);
    for (int c = 2; c < 5; c++) empty_rec(c);

    // 5: orange+pink on one pixel at (4,2)
    clear_px();
    px[20] = 5'b00011;
    run_frame(32);
    get_rec(0, 1, 4, 4, 2, 2, 4, 2);
    get_rec(1, 1, 4, 4, 2, 2, 4, 2);
    for (int c = 2; c < 5; c++) empty_rec(c);

    // sop+eop on the same beat is counted as pixel (0,0)
    clear_px();
    px[0] = 5'b01000;
    run_frame(1);
    for (int c = 0; c < 3; c++) empty_rec(c);
    get_rec(3, 1, 0, 0, 0, 0, 0, 0);
    empty_rec(4);

    // 40-beat frame: y saturates at 3, green lands at (3,3)
    clear_px();
    px[35] = 5'b10000;
    run_frame(40);
    for (int c = 0; c < 4; c++) empty_rec(c);
    get_rec(4, 1, 3, 3, 3, 3, 3, 3);
    check_idle("after_sat");

`ifdef CENTROID_EN
    // 6: green at (1,0),(3,2) -> centroid (2,1); empty orange record is not stalled
    clear_px();
    px[1]  = 5'b10000;
    px[19] = 5'b10000;
    run_frame(32);
    chk("cen_no_stall", 32'(out_valid), 32'd1);
    for (int c = 0; c < 4; c++) empty_rec(c);
    get_rec(4, 2, 1, 3, 0, 2, 2, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
